// File: rtl/gate_sweep_controller.sv
// Sweeps all eight vectors into a 3-input gate, samples the gate output after a settle window and
// checks it against TRUTH_TABLE. Define GATE_SWEEP_FAIL_MASK_EN to add a per-vector fail_mask output.
module gate_sweep_controller #(
   parameter logic [7:0]  TRUTH_TABLE   = 8'b1000_0000,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       gate_out,
   output logic       drv_a,
   output logic       drv_b,
   output logic       drv_c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] first_fail,
   output logic       first_fail_valid
`ifdef GATE_SWEEP_FAIL_MASK_EN
   ,
   output logic [7:0] fail_mask
`endif
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned VEC_W = 3;
   localparam int unsigned ERR_W = 4;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [1:0]       state, state_nxt;
   logic [VEC_W-1:0] vec, vec_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [VEC_W-1:0] drv, drv_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             pass_nxt;
   logic [ERR_W-1:0] err_nxt;
   logic [VEC_W-1:0] ff_nxt;
   logic             ffv_nxt;
   logic             mismatch_c;
   logic [7:0]       mask, mask_nxt;

   assign mismatch_c = (gate_out != TRUTH_TABLE[vec]);

   // Next-state and next-output logic.
   always_comb begin
      state_nxt = state;
      vec_nxt   = vec;
      cnt_nxt   = cnt;
      drv_nxt   = drv;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      pass_nxt  = pass;
      err_nxt   = err_count;
      ff_nxt    = first_fail;
      ffv_nxt   = first_fail_valid;
      mask_nxt  = mask;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SETTLE;
               vec_nxt   = '0;
               drv_nxt   = '0;
               cnt_nxt   = '0;
               err_nxt   = '0;
               ff_nxt    = '0;
               ffv_nxt   = 1'b0;
               pass_nxt  = 1'b0;
               busy_nxt  = 1'b1;
               mask_nxt  = '0;
            end
         end
         SETTLE: begin
            if (cnt == CNT_LAST) begin
               state_nxt = SAMPLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         SAMPLE: begin
            if (mismatch_c) begin
               err_nxt       = err_count + ERR_W'(1);
               mask_nxt[vec] = 1'b1;
               if (!first_fail_valid) begin
                  ff_nxt  = vec;
                  ffv_nxt = 1'b1;
               end
            end
            // Verdict is published together with the done pulse.
            if (vec == VEC_W'(7)) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
               pass_nxt  = (err_nxt == '0);
            end else begin
               state_nxt = SETTLE;
               vec_nxt   = vec + VEC_W'(1);
               drv_nxt   = vec + VEC_W'(1);
               cnt_nxt   = '0;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            drv_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         vec              <= '0;
         cnt              <= '0;
         drv              <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail       <= '0;
         first_fail_valid <= 1'b0;
         mask             <= '0;
      end else begin
         state            <= state_nxt;
         vec              <= vec_nxt;
         cnt              <= cnt_nxt;
         drv              <= drv_nxt;
         busy             <= busy_nxt;
         done             <= done_nxt;
         pass             <= pass_nxt;
         err_count        <= err_nxt;
         first_fail       <= ff_nxt;
         first_fail_valid <= ffv_nxt;
         mask             <= mask_nxt;
      end
   end

   assign drv_a = drv[2];
   assign drv_b = drv[1];
   assign drv_c = drv[0];

`ifdef GATE_SWEEP_FAIL_MASK_EN
   assign fail_mask = mask;
`else
   logic unused_mask;
   assign unused_mask = ^mask;
`endif

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Bench for gate_sweep_controller: a schedule-level model checked every cycle plus directed
// sweeps (AND default build, and a NOR instance with a one-cycle settle window).
module tb_gate_sweep_controller;

   logic clk = 1'b0;
   logic rst_n, start, start2;
   int   mode;  // 0 = correct AND, 1 = tied 0, 2 = tied 1

   logic a1, b1, c1, busy1, done1, pass1, ffv1, gate1;
   logic [3:0] err1;
   logic [2:0] ff1;
   logic a2, b2, c2, busy2, done2, pass2, ffv2, gate2;
   logic [3:0] err2;
   logic [2:0] ff2;
`ifdef GATE_SWEEP_FAIL_MASK_EN
   logic [7:0] mask1, mask2;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign gate1 = (mode == 0) ? (a1 & b1 & c1) : ((mode == 1) ? 1'b0 : 1'b1);
   assign gate2 = ~(a2 | b2 | c2);

   gate_sweep_controller dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .gate_out(gate1),
      .drv_a(a1), .drv_b(b1), .drv_c(c1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_fail(ff1), .first_fail_valid(ffv1)
`ifdef GATE_SWEEP_FAIL_MASK_EN
      , .fail_mask(mask1)
`endif
   );

   gate_sweep_controller #(.TRUTH_TABLE(8'b0000_0001), .SETTLE_CYCLES(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .gate_out(gate2),
      .drv_a(a2), .drv_b(b2), .drv_c(c2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .first_fail(ff2), .first_fail_valid(ffv2)
`ifdef GATE_SWEEP_FAIL_MASK_EN
      , .fail_mask(mask2)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a sweep is an elapsed-edge count t since start acceptance; everything follows from t.
   typedef struct {
      bit       known;
      bit       active;
      int       t;
      int       err;
      int       ff;
      bit       ffv;
      bit       pass;
      bit [7:0] mask;
   } model_t;

   model_t m1 = '{default: 0};
   model_t m2 = '{default: 0};

   function automatic bit gate_val(input int md, input int k);
      case (md)
         0:       return (k == 7);
         1:       return 1'b0;
         2:       return 1'b1;
         default: return (k == 0);
      endcase
   endfunction

   function automatic model_t step(input model_t m, input bit rst, input bit st, input int s,
                                   input bit [7:0] tt, input int md);
      model_t r;
      int k;
      r = m;
      if (!rst) begin
         r = '{default: 0};
         r.known = 1'b1;
      end else if (m.active) begin
         if (m.t == 8 * (s + 1)) begin
            r.active = 1'b0;
         end else begin
            if ((m.t % (s + 1)) == s) begin
               k = m.t / (s + 1);
               if (gate_val(md, k) != tt[k]) begin
                  r.err++;
                  r.mask[k] = 1'b1;
                  if (!r.ffv) begin
                     r.ff  = k;
                     r.ffv = 1'b1;
                  end
               end
               if (k == 7) r.pass = (r.err == 0);
            end
            r.t = m.t + 1;
         end
      end else if (st) begin
         r.active = 1'b1;
         r.t      = 0;
         r.err    = 0;
         r.ff     = 0;
         r.ffv    = 1'b0;
         r.pass   = 1'b0;
         r.mask   = '0;
      end
      return r;
   endfunction

   task automatic cmp(input string tag, input model_t m, input int s, input logic [13:0] act);
      logic [13:0] e;
      int v;
      v = m.active ? ((m.t < 8 * (s + 1)) ? m.t / (s + 1) : 7) : 0;
      e = {3'(v), m.active, (m.active && m.t == 8 * (s + 1)), m.pass, 4'(m.err), 3'(m.ff), m.ffv};
      check(tag, 32'(act), 32'(e));
   endtask

   always @(posedge clk) begin
      m1 = step(m1, rst_n, start, 2, 8'h80, mode);
      m2 = step(m2, rst_n, start2, 1, 8'h01, 3);
   end

   always @(negedge clk) begin
      if (m1.known) begin
         cmp("cycle_dut1", m1, 2, {a1, b1, c1, busy1, done1, pass1, err1, ff1, ffv1});
         cmp("cycle_dut2", m2, 1, {a2, b2, c2, busy2, done2, pass2, err2, ff2, ffv2});
`ifdef GATE_SWEEP_FAIL_MASK_EN
         check("cycle_mask1", 32'(mask1), 32'(m1.mask));
         check("cycle_mask2", 32'(mask2), 32'(m2.mask));
`endif
      end
   end

   // Pulses start on one instance and returns the edge count from acceptance to done (0 = timeout).
   task automatic sweep(input bit second, input bit extra, output int n);
      if (second) start2 = 1'b1;
      else        start  = 1'b1;
      @(posedge clk); #2;
      start  = 1'b0;
      start2 = 1'b0;
      check("busy_after_start", 32'(second ? busy2 : busy1), 32'd1);
      if (second) check("nor_drv_seq", 32'({a2, b2, c2}), 32'd0);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #2;
         start = extra && (i == 4 || i == 11);
         if (second && i < 16) check("nor_drv_seq", 32'({a2, b2, c2}), 32'(i / 2));
         if (second ? done2 : done1) begin
            n = i;
            break;
         end
      end
      start = 1'b0;
   endtask

   int n, dones;

   initial begin
      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_outputs", 32'({a1, b1, c1, busy1, done1, pass1, err1, ff1, ffv1}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      // Correct AND gate.
      mode = 0;
      sweep(1'b0, 1'b0, n);
      check("and_done_latency", 32'(n), 32'd24);
      @(posedge clk); #2;
      check("and_result", 32'({busy1, pass1, err1, ffv1}), 32'b0_1_0000_0);

      // Gate stuck at 0: only vector 7 fails.
      mode = 1;
      sweep(1'b0, 1'b0, n);
      check("tie0_done_latency", 32'(n), 32'd24);
      @(posedge clk); #2;
      check("tie0_result", 32'({pass1, err1, ff1, ffv1}), 32'b0_0001_111_1);
`ifdef GATE_SWEEP_FAIL_MASK_EN
      check("tie0_mask", 32'(mask1), 32'h80);
`endif

      // Gate stuck at 1: vectors 0..6 fail.
      mode = 2;
      sweep(1'b0, 1'b0, n);
      @(posedge clk); #2;
      check("tie1_result", 32'({pass1, err1, ff1, ffv1}), 32'b0_0111_000_1);
`ifdef GATE_SWEEP_FAIL_MASK_EN
      check("tie1_mask", 32'(mask1), 32'h7F);
`endif

      // Start pulses mid-sweep are ignored; a later start runs a clean sweep.
      mode = 0;
      sweep(1'b0, 1'b1, n);
      check("restart_ignored_latency", 32'(n), 32'd24);
      repeat (2) @(posedge clk);
      #2;
      check("idle_after_extra_starts", 32'({busy1, done1}), 32'd0);
      sweep(1'b0, 1'b0, n);
      check("second_sweep_latency", 32'(n), 32'd24);
      @(posedge clk); #2;
      check("second_sweep_result", 32'({pass1, err1, ffv1}), 32'b1_0000_0);

      // Reset during vector 4 settle, with start high on the same edge.
      mode = 1;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b1;
      start = 1'b0;
      check("abort_reset_outputs", 32'({a1, b1, c1, busy1, done1, pass1, err1, ff1, ffv1}), 32'd0);
      dones = 0;
      repeat (40) begin
         @(posedge clk); #2;
         if (done1) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);

      // NOR table with a one-cycle settle window.
      sweep(1'b1, 1'b0, n);
      check("nor_done_latency", 32'(n), 32'd16);
      @(posedge clk); #2;
      check("nor_result", 32'({busy2, pass2, err2, ffv2}), 32'b0_1_0000_0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
